// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Requester, memory-port and status bundle of mem_port_arbiter.
//            master = arbiter view, slave = requesters/memory view.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int LINE_WORDS = 4
);
    localparam int IDX_W = $clog2(LINE_WORDS);

    logic             if_req;
    logic [31:0]      if_addr;
    logic [31:0]      if_rdata;
    logic             if_rvalid;
    logic [IDX_W-1:0] if_word_idx;
    logic             if_done;

    logic             d_req;
    logic             d_we;
    logic [31:0]      d_addr;
    logic [31:0]      d_wdata;
    logic [31:0]      d_rdata;
    logic             d_done;

    logic             mem_req;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             mem_ack;
    logic [31:0]      mem_rdata;

    logic             stall;
    logic [1:0]       grant;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        output if_rdata, if_rvalid, if_word_idx, if_done, d_rdata, d_done,
        output mem_req, mem_we, mem_addr, mem_wdata, stall, grant
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_ack, mem_rdata,
        input  if_rdata, if_rvalid, if_word_idx, if_done, d_rdata, d_done,
        input  mem_req, mem_we, mem_addr, mem_wdata, stall, grant
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between icache line refill (burst) and
//            data load/store (single word), data first with bounded starvation.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int LINE_WORDS   = 4,
    parameter int MAX_D_STREAK = 4
) (
    input  wire                clk,
    input  wire                start_n,
    mem_port_arbiter_if.master bus
);
    localparam int IDX_W    = $clog2(LINE_WORDS);
    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam int TAG_W    = 32 - IDX_W - 2;

    localparam logic [IDX_W-1:0]    LAST_BEAT    = IDX_W'(LINE_WORDS - 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX   = STREAK_W'(MAX_D_STREAK);
    localparam logic [1:0]          GRANT_IDLE   = 2'b00;
    localparam logic [1:0]          GRANT_DATA   = 2'b01;
    localparam logic [1:0]          GRANT_IFETCH = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_D_XFER = 2'd1,
        S_I_XFER = 2'd2
    } state_t;

    state_t              state_q,       state_d;
    logic [STREAK_W-1:0] d_streak_q,    d_streak_d;
    logic [IDX_W-1:0]    beat_q,        beat_d;
    logic [TAG_W-1:0]    line_tag_q,    line_tag_d;
    logic                mem_req_q,     mem_req_d;
    logic                mem_we_q,      mem_we_d;
    logic [31:0]         mem_addr_q,    mem_addr_d;
    logic [31:0]         mem_wdata_q,   mem_wdata_d;
    logic [31:0]         if_rdata_q,    if_rdata_d;
    logic                if_rvalid_q,   if_rvalid_d;
    logic [IDX_W-1:0]    if_word_idx_q, if_word_idx_d;
    logic                if_done_q,     if_done_d;
    logic [31:0]         d_rdata_q,     d_rdata_d;
    logic                d_done_q,      d_done_d;
    logic [1:0]          grant_q,       grant_d;

    logic [IDX_W-1:0]    beat_inc;
    logic                data_wins;
    logic                unused_line_offset;

    assign beat_inc           = beat_q + IDX_W'(1);
    assign unused_line_offset = ^bus.if_addr[IDX_W+1:0];
    // Data loses only when ifetch has been passed over MAX_D_STREAK times in a row.
    assign data_wins = bus.d_req && !(bus.if_req && (d_streak_q == STREAK_MAX));

    always_comb begin
        state_d       = state_q;
        d_streak_d    = bus.if_req ? d_streak_q : '0;
        beat_d        = beat_q;
        line_tag_d    = line_tag_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        if_rdata_d    = if_rdata_q;
        if_rvalid_d   = 1'b0;
        if_word_idx_d = if_word_idx_q;
        if_done_d     = 1'b0;
        d_rdata_d     = d_rdata_q;
        d_done_d      = 1'b0;
        grant_d       = grant_q;

        case (state_q)
            S_IDLE: begin
                if (data_wins) begin
                    state_d     = S_D_XFER;
                    grant_d     = GRANT_DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    if (bus.if_req && (d_streak_q != STREAK_MAX)) begin
                        d_streak_d = d_streak_q + STREAK_W'(1);
                    end
                end else if (bus.if_req) begin
                    state_d    = S_I_XFER;
                    grant_d    = GRANT_IFETCH;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    line_tag_d = bus.if_addr[31:IDX_W+2];
                    mem_addr_d = {bus.if_addr[31:IDX_W+2], {(IDX_W+2){1'b0}}};
                    beat_d     = '0;
                    d_streak_d = '0;
                end
            end
            S_D_XFER: begin
                if (bus.mem_ack) begin
                    if (!mem_we_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end
                    d_done_d  = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    grant_d   = GRANT_IDLE;
                    state_d   = S_IDLE;
                end
            end
            S_I_XFER: begin
                if (bus.mem_ack) begin
                    if_rdata_d    = bus.mem_rdata;
                    if_rvalid_d   = 1'b1;
                    if_word_idx_d = beat_q;
                    if (beat_q == LAST_BEAT) begin
                        if_done_d = 1'b1;
                        mem_req_d = 1'b0;
                        beat_d    = '0;
                        grant_d   = GRANT_IDLE;
                        state_d   = S_IDLE;
                    end else begin
                        beat_d     = beat_inc;
                        mem_addr_d = {line_tag_q, beat_inc, 2'b00};
                    end
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
                grant_d   = GRANT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge start_n) begin
        if (!start_n) begin
            state_q       <= S_IDLE;
            d_streak_q    <= '0;
            beat_q        <= '0;
            line_tag_q    <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            if_rdata_q    <= '0;
            if_rvalid_q   <= 1'b0;
            if_word_idx_q <= '0;
            if_done_q     <= 1'b0;
            d_rdata_q     <= '0;
            d_done_q      <= 1'b0;
            grant_q       <= GRANT_IDLE;
        end else begin
            state_q       <= state_d;
            d_streak_q    <= d_streak_d;
            beat_q        <= beat_d;
            line_tag_q    <= line_tag_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            if_rdata_q    <= if_rdata_d;
            if_rvalid_q   <= if_rvalid_d;
            if_word_idx_q <= if_word_idx_d;
            if_done_q     <= if_done_d;
            d_rdata_q     <= d_rdata_d;
            d_done_q      <= d_done_d;
            grant_q       <= grant_d;
        end
    end

    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.if_rvalid   = if_rvalid_q;
    assign bus.if_word_idx = if_word_idx_q;
    assign bus.if_done     = if_done_q;
    assign bus.d_rdata     = d_rdata_q;
    assign bus.d_done      = d_done_q;
    assign bus.grant       = grant_q;
    assign bus.stall       = (bus.if_req & ~if_done_q) | (bus.d_req & ~d_done_q);
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed bench: data-access vector table plus refill, starvation,
//            collision and mid-burst reset sequences against a wait-state memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    localparam int LINE_WORDS = 4;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ws;
        logic [31:0] mem_data;
        logic [31:0] exp_rdata;
    } dvec_t;

    logic        clk = 1'b0;
    logic        start_n;
    int          nvec = 0;
    int          nerr = 0;
    int          wait_cfg = 0;
    int          wcnt = 0;
    bit          fixed_en = 1'b0;
    logic [31:0] fixed_data = '0;
    dvec_t       tbl [5];

    mem_port_arbiter_if #(.LINE_WORDS(LINE_WORDS)) bus ();

    mem_port_arbiter #(
        .LINE_WORDS  (LINE_WORDS),
        .MAX_D_STREAK(4)
    ) dut (
        .clk    (clk),
        .start_n(start_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'hA5C3_0F00;
    endfunction

    // Memory model: acks after wait_cfg idle cycles of a held request.
    always @(negedge clk) begin
        if (bus.mem_req && start_n) begin
            if (wcnt < wait_cfg) begin
                wcnt = wcnt + 1;
                bus.mem_ack = 1'b0;
            end else begin
                wcnt = 0;
                bus.mem_ack = 1'b1;
                bus.mem_rdata = fixed_en ? fixed_data : mem_fn(bus.mem_addr);
            end
        end else begin
            wcnt = 0;
            bus.mem_ack = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec = nvec + 1;
        if (act !== exp) begin
            nerr = nerr + 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_data(input dvec_t v);
        int cnt;
        wait_cfg   = v.ws;
        fixed_en   = 1'b1;
        fixed_data = v.mem_data;
        @(negedge clk);
        bus.d_req   = 1'b1;
        bus.d_we    = v.we;
        bus.d_addr  = v.addr;
        bus.d_wdata = v.wdata;
        @(posedge clk); #1;
        chk("d_grant", 32'(bus.grant), 32'h1);
        chk("d_mem_req", 32'(bus.mem_req), 32'h1);
        chk("d_mem_addr", bus.mem_addr, v.addr);
        chk("d_mem_we", 32'(bus.mem_we), 32'(v.we));
        chk("d_mem_wdata", bus.mem_wdata, v.wdata);
        bus.d_addr  = ~v.addr;
        bus.d_wdata = ~v.wdata;
        bus.d_we    = ~v.we;
        cnt = 0;
        while (cnt < 50) begin
            @(posedge clk); #1;
            cnt = cnt + 1;
            if (bus.d_done) break;
            chk("d_hold_req", 32'(bus.mem_req), 32'h1);
            chk("d_hold_addr", bus.mem_addr, v.addr);
            chk("d_hold_wdata", bus.mem_wdata, v.wdata);
        end
        chk("d_latency", 32'(cnt), 32'(v.ws + 1));
        chk("d_rdata", bus.d_rdata, v.exp_rdata);
        chk("d_done_mem_req", 32'(bus.mem_req), 32'h0);
        bus.d_req = 1'b0;
        @(posedge clk); #1;
        chk("d_done_pulse", 32'(bus.d_done), 32'h0);
        chk("d_idle_grant", 32'(bus.grant), 32'h0);
    endtask

    // Caller must be away from the rising edge with the arbiter free to grant.
    task automatic run_refill(input logic [31:0] addr, input int ws);
        logic [31:0] base;
        int k;
        int cyc;
        base        = {addr[31:4], 4'h0};
        wait_cfg    = ws;
        fixed_en    = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        k   = 0;
        cyc = 0;
        while (cyc < 200) begin
            @(posedge clk); #1;
            cyc = cyc + 1;
            if (bus.if_rvalid) begin
                chk("i_word_idx", 32'(bus.if_word_idx), 32'(k));
                chk("i_rdata", bus.if_rdata, mem_fn(base + 32'(4 * k)));
                chk("i_done", 32'(bus.if_done), 32'(k == LINE_WORDS - 1));
                k = k + 1;
                if (bus.if_done) break;
            end
            if (bus.mem_req) begin
                chk("i_mem_addr", bus.mem_addr, base + 32'(4 * k));
                chk("i_grant", 32'(bus.grant), 32'h2);
            end
        end
        chk("i_beats", 32'(k), 32'(LINE_WORDS));
        chk("i_done_mem_req", 32'(bus.mem_req), 32'h0);
        bus.if_req = 1'b0;
        @(posedge clk); #1;
        chk("i_after_stall", 32'(bus.stall), 32'h0);
        chk("i_after_grant", 32'(bus.grant), 32'h0);
        chk("i_after_rvalid", 32'(bus.if_rvalid), 32'h0);
    endtask

    initial begin
        logic [1:0] exp_seq [6];
        logic [1:0] got_seq [6];
        logic [1:0] prev;
        int         ng;
        int         cyc;
        int         k;
        bit         done;

        tbl[0] = '{1'b0, 32'h0000_0040, 32'h0000_0000, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        tbl[1] = '{1'b1, 32'h0000_0080, 32'h0000_1234, 5, 32'h7777_7777, 32'hDEAD_BEEF};
        tbl[2] = '{1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 2, 32'h0BAD_F00D, 32'h0BAD_F00D};
        tbl[3] = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 0, 32'h1111_1111, 32'h0BAD_F00D};
        tbl[4] = '{1'b0, 32'h0000_1000, 32'h0000_0000, 1, 32'h1357_9BDF, 32'h1357_9BDF};
        exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};

        start_n       = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        #2;
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_d_done", 32'(bus.d_done), 32'h0);
        chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'h0);
        chk("rst_stall", 32'(bus.stall), 32'h0);
        @(negedge clk);
        start_n = 1'b1;

        for (int i = 0; i < 5; i++) do_data(tbl[i]);

        @(negedge clk);
        run_refill(32'h0000_010C, 1);

        // Starvation bound: both requesters held high.
        wait_cfg   = 0;
        fixed_en   = 1'b1;
        fixed_data = 32'h0;
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0500;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h0000_0044;
        ng   = 0;
        cyc  = 0;
        prev = 2'b00;
        while (ng < 6 && cyc < 300) begin
            @(posedge clk); #1;
            cyc = cyc + 1;
            if (bus.grant != 2'b00 && prev == 2'b00) begin
                got_seq[ng] = bus.grant;
                ng = ng + 1;
            end
            if (bus.if_done) bus.if_req = 1'b0;
            prev = bus.grant;
        end
        chk("starve_grants", 32'(ng), 32'h6);
        for (int i = 0; i < 6; i++) chk("starve_seq", 32'(got_seq[i]), 32'(exp_seq[i]));
        bus.d_req = 1'b0;
        cyc = 0;
        while (!bus.d_done && cyc < 50) begin
            @(posedge clk); #1;
            cyc = cyc + 1;
        end
        chk("drop_req_done", 32'(bus.d_done), 32'h1);
        @(posedge clk); #1;

        // Collision: data request arrives mid-burst and waits for if_done.
        wait_cfg = 1;
        fixed_en = 1'b0;
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0600;
        k    = 0;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc = cyc + 1;
            chk("coll_stall", 32'(bus.stall), 32'h1);
            if (bus.if_rvalid && k == 0) begin
                bus.d_req  = 1'b1;
                bus.d_we   = 1'b0;
                bus.d_addr = 32'h0000_0700;
            end
            if (bus.if_rvalid) k = k + 1;
            if (bus.if_done) begin
                done = 1'b1;
                bus.if_req = 1'b0;
            end else begin
                chk("coll_grant_i", 32'(bus.grant), 32'h2);
            end
        end
        chk("coll_beats", 32'(k), 32'h4);
        @(posedge clk); #1;
        chk("coll_grant_d", 32'(bus.grant), 32'h1);
        chk("coll_addr", bus.mem_addr, 32'h0000_0700);
        chk("coll_stall_d", 32'(bus.stall), 32'h1);
        cyc = 0;
        while (!bus.d_done && cyc < 50) begin
            @(posedge clk); #1;
            cyc = cyc + 1;
        end
        chk("coll_d_done", 32'(bus.d_done), 32'h1);
        bus.d_req = 1'b0;
        @(posedge clk); #1;

        // Reset during beat 2 of a refill.
        wait_cfg = 1;
        fixed_en = 1'b0;
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0404;
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk); #1;
            cyc = cyc + 1;
            if (bus.if_rvalid && bus.if_word_idx == 2'd1) break;
        end
        chk("rb_mid_addr", bus.mem_addr, 32'h0000_0408);
        #2;
        start_n = 1'b0;
        #1;
        chk("rb_mem_req", 32'(bus.mem_req), 32'h0);
        chk("rb_mem_addr", bus.mem_addr, 32'h0);
        chk("rb_grant", 32'(bus.grant), 32'h0);
        chk("rb_if_rvalid", 32'(bus.if_rvalid), 32'h0);
        chk("rb_if_idx", 32'(bus.if_word_idx), 32'h0);
        chk("rb_if_rdata", bus.if_rdata, 32'h0);
        chk("rb_d_rdata", bus.d_rdata, 32'h0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("rb_no_done", 32'(bus.if_done), 32'h0);
        end
        @(negedge clk);
        start_n = 1'b1;
        run_refill(32'h0000_0404, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
`default_nettype wire
